// File: rtl/picnic_sm4_pkg.sv
// Shared parameters for the Picnic-on-SM4 signer datapath.
// Field widths and res2 FSM state encoding.
package picnic_sm4_pkg;

  localparam int N_PARTY = 16;
  localparam int COM_W   = 256;
  localparam int IDX_W   = 8;

  localparam int SEED_W  = 128;
  localparam int SALT_W  = 256;
  localparam int AUX_W   = 1024;
  localparam int MSG_W   = 512;
  localparam int SL_W    = 512;
  localparam int KEY_W   = 128;

  localparam logic [IDX_W-1:0] N_PARTY_IDX = IDX_W'(N_PARTY);
  localparam logic [IDX_W-1:0] LAST_K      = IDX_W'(N_PARTY - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LATCH = 3'd1;
  localparam logic [2:0] S_SCAN  = 3'd2;
  localparam logic [2:0] S_HASH  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

endpackage

// File: rtl/com_select_scan.sv
// Constant-time commitment selector: walks all parties,
// capturing the slice whose index matches j.
module com_select_scan
  import picnic_sm4_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     start,
  input  logic [IDX_W-1:0]         j,
  input  logic [N_PARTY*COM_W-1:0] c_all,
  output logic [COM_W-1:0]         c_j,
  output logic                     done
);

  logic [IDX_W-1:0] k;
  logic             busy;

  // Scan every party once so timing never depends on j.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k    <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      c_j  <= '0;
    end else begin
      done <= 1'b0;
      if (clr) c_j <= '0;
      if (start) begin
        busy <= 1'b1;
        k    <= '0;
      end else if (busy) begin
        if (k == j) c_j <= c_all[k*COM_W +: COM_W];
        if (k == LAST_K) begin
          busy <= 1'b0;
          done <= 1'b1;
          k    <= '0;
        end else begin
          k <= k + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/round_fun_for_sign_res2.sv
// Signer-side res2 round function: builds the per-round response
// record and drives the external H_for_Cn engine for opened rounds.
module round_fun_for_sign_res2
  import picnic_sm4_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sign_res2_start,
  input  logic                     t_in_LC,
  input  logic [IDX_W-1:0]         t,
  input  logic [IDX_W-1:0]         j,
  input  logic [SEED_W-1:0]        seed_i,
  input  logic [SALT_W-1:0]        salt,
  input  logic [SL_W-1:0]          seed_lambda_i,
  input  logic [AUX_W-1:0]         aux_triangle_i,
  input  logic [KEY_W-1:0]         masked_key_i,
  input  logic [MSG_W-1:0]         msgs_i,
  input  logic [N_PARTY*COM_W-1:0] C_all,
  output logic                     cn_start,
  input  logic                     cn_end,
  input  logic [COM_W-1:0]         cn_in,
  output logic [SL_W-1:0]          hash_seed_lambda,
  output logic [AUX_W-1:0]         hash_aux,
  output logic [SALT_W-1:0]        hash_salt,
  output logic [IDX_W-1:0]         t_out,
  output logic                     opened,
  output logic [COM_W-1:0]         C_j,
  output logic [COM_W-1:0]         Cn,
  output logic [AUX_W-1:0]         aux_out,
  output logic [KEY_W-1:0]         masked_key_out,
  output logic [MSG_W-1:0]         msgs_out,
  output logic [SEED_W-1:0]        seed_out,
  output logic                     idx_err,
  output logic                     sign_res2_end
);

  logic [2:0]       state;
  logic [IDX_W-1:0] j_q;
  logic             accept;
  logic             scan_start;
  logic             scan_done;

  assign accept     = (state == S_IDLE) && sign_res2_start && !sign_res2_end;
  assign scan_start = (state == S_LATCH) && opened && (j_q < N_PARTY_IDX);
  // Decoded from state so an async reset drops it at once.
  assign cn_start   = (state == S_HASH);

  com_select_scan u_scan (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .start (scan_start),
    .j     (j_q),
    .c_all (C_all),
    .c_j   (C_j),
    .done  (scan_done)
  );

  // Control FSM plus latching of the response fields.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= S_IDLE;
      j_q              <= '0;
      t_out            <= '0;
      opened           <= 1'b0;
      seed_out         <= '0;
      aux_out          <= '0;
      masked_key_out   <= '0;
      msgs_out         <= '0;
      hash_seed_lambda <= '0;
      hash_aux         <= '0;
      hash_salt        <= '0;
      Cn               <= '0;
      idx_err          <= 1'b0;
      sign_res2_end    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (sign_res2_end && !sign_res2_start) sign_res2_end <= 1'b0;
          if (accept) begin
            j_q              <= j;
            t_out            <= t;
            opened           <= t_in_LC;
            seed_out         <= seed_i;
            aux_out          <= aux_triangle_i;
            masked_key_out   <= masked_key_i;
            msgs_out         <= msgs_i;
            hash_seed_lambda <= seed_lambda_i;
            hash_aux         <= aux_triangle_i;
            hash_salt        <= salt;
            Cn               <= '0;
            idx_err          <= 1'b0;
            state            <= S_LATCH;
          end
        end
        S_LATCH: begin
          if (!opened) begin
            state <= S_DONE;
          end else if (j_q >= N_PARTY_IDX) begin
            idx_err <= 1'b1;
            state   <= S_DONE;
          end else begin
            state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (scan_done) state <= S_HASH;
        end
        S_HASH: begin
          if (cn_end) begin
            Cn    <= cn_in;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          sign_res2_end <= 1'b1;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/round_fun_for_sign_res2.md
Name: round_fun_for_sign_res2

Overview:
Signer-side counterpart of the verifier's res2 round function in the Picnic-on-SM4 (KKW) datapath. For one round t it builds the response record that the verifier later consumes:
- Opened round (t_in_LC=1): commitment C_j of the unopened party j, aux, masked key, msgs, and Cn = H(seed_lambda, aux, salt).
- Unopened round: the round seed.

Cn is computed by the existing external H_for_Cn engine. This block drives that engine through a start/end handshake and sits between the per-round MPC state store and the signature serializer.

Parameters:
N_PARTY, 16, number of MPC parties (commitments per round)
COM_W, 256, commitment / hash digest width
IDX_W, 8, width of t and j

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
sign_res2_start  in  1  level request; a rising use is start=1 while state IDLE and sign_res2_end=0
t_in_LC  in  1  round t is opened
t  in  IDX_W  round index (latched, echoed)
j  in  IDX_W  unopened party index
seed_i  in  128  round seed
salt  in  256  signature salt
seed_lambda_i  in  512  preprocessing seed material
aux_triangle_i  in  1024  aux bits
masked_key_i  in  128  masked key
msgs_i  in  512  broadcast messages of party j
C_all  in  N_PARTY*COM_W  all party commitments, party k at bits [k*COM_W +: COM_W]
cn_start  out  1  request to H_for_Cn
cn_end  in  1  H_for_Cn done
cn_in  in  COM_W  H_for_Cn digest
hash_seed_lambda / hash_aux / hash_salt  out  512/1024/256  latched operands to H_for_Cn
t_out  out  IDX_W  latched t
opened  out  1  latched t_in_LC
C_j  out  COM_W  selected commitment
Cn  out  COM_W  captured digest
aux_out / masked_key_out / msgs_out / seed_out  out  1024/128/512/128  latched response fields
idx_err  out  1  j >= N_PARTY
sign_res2_end  out  1  response valid

Behaviour:
- Reset (async, reset=0): all outputs are 0, state is IDLE, scan counter k is 0. Reset mid-operation aborts the operation with no residue, and cn_start drops immediately.
- IDLE: when start=1 and end=0, latch every input field, t, j and t_in_LC in one cycle, then go to LATCH.
- LATCH: if opened=0, go to DONE. If opened=1 and j>=N_PARTY, set idx_err=1, leave C_j=0 and Cn=0, and go to DONE. Otherwise clear k and go to SCAN.
- SCAN: one party per cycle. When k==j, capture C_all slice k into C_j. The scan always runs the full N_PARTY cycles, k=0..N_PARTY-1, so timing is constant and independent of j. Then go to HASH.
- HASH: hold cn_start=1 with stable operands. On the first cycle with cn_end=1, capture cn_in into Cn, drop cn_start on the next edge and go to DONE. cn_end is ignored in every other state.
- DONE: set sign_res2_end=1 and return to IDLE.
  - end stays high while start=1.
  - end clears on the first cycle start=0.
  - If start was already 0 at DONE, end is high for exactly one cycle.
  - A new operation needs start=0 to have been seen, so there is no retrigger while end=1.
- Latency from accepted start to end:
  - Unopened: 2 cycles.
  - Opened: 2 + N_PARTY + hash latency + 1.
- Output fields hold their values until the next accepted start. They are not cleared when start is deasserted.
- Deasserting start mid-operation does not abort the operation.

Decomposition:
- Shared package picnic_sm4_pkg holds:
  - N_PARTY, COM_W, IDX_W
  - field widths (SEED_W=128, SALT_W=256, AUX_W=1024, MSG_W=512, SL_W=512)
  - state encoding IDLE/LATCH/SCAN/HASH/DONE
- One natural sub-module: com_select_scan, containing the counter, the compare and the capture of C_j, with its own start/done pair.
- H_for_Cn remains external.

Test Plan:
- Unopened round: t_in_LC=0, seed_i=128'hA5..A5, start held high → end=1 exactly 2 cycles after acceptance; seed_out=A5..A5, cn_start never asserted, C_j=0; end clears one cycle after start drops.
- Opened round: t_in_LC=1, j=5, C_all party k = {k replicated}, hash model returns 256'hDEAD.. after 7 cycles → C_j = party-5 pattern, Cn=DEAD.., cn_start high for 7+1 cycles, end at 2+16+8+1 cycles.
- Index error: j=16 → idx_err=1, cn_start never high, end 2 cycles after acceptance.
- Boundary indices: j=0 and j=15 → correct first and last slices selected, with identical latency.
- Start pulsed for one cycle only → operation completes and end is high for exactly one cycle; a second start while end=1 is ignored.
- Reset asserted during HASH → all outputs 0 immediately, cn_start=0; a subsequent opened round with j=3 completes correctly.
